// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle for the instruction cache.
// slave: the cache side; master: the IF stage / mem_ctrl side.
interface icache_if;
  logic        if_req;
  logic [31:0] if_pc;
  logic        inst_ok;
  logic [31:0] inst_o;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  modport slave (
    input  if_req, if_pc, mem_ack, mem_data,
    output inst_ok, inst_o, mem_req, mem_addr
  );

  modport master (
    output if_req, if_pc, mem_ack, mem_data,
    input  inst_ok, inst_o, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and mem_ctrl.
// Define ICACHE_STATS_EN to add the hit_cnt / miss_cnt counter outputs.
module icache #(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        inv,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned NumLines = 2 ** INDEX_WIDTH;
  localparam int unsigned TagWidth = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic [0:0] {StIdle, StMiss} state_e;

  state_e                  state_q, state_d;
  logic [NumLines-1:0]     valid_q;
  logic [TagWidth-1:0]     tag_q  [NumLines];
  logic [31:0]             data_q [NumLines];
  // Word address of the outstanding miss: index in the low bits, tag above.
  logic [ADDR_WIDTH-3:0]   miss_pc_q, miss_pc_d;
  logic                    cancel_q, cancel_d;
  logic                    inst_ok_q, inst_ok_d;
  logic [31:0]             inst_o_q, inst_o_d;
  logic                    mem_req_q, mem_req_d;
  logic [31:0]             mem_addr_q, mem_addr_d;

  logic                    hit, fill, acc_hit, acc_miss;
  logic [INDEX_WIDTH-1:0]  req_idx, fill_idx;
  logic [TagWidth-1:0]     req_tag, fill_tag;
  logic                    unused_pc_bits;

  assign req_idx        = bus.if_pc[INDEX_WIDTH+1:2];
  assign req_tag        = bus.if_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign fill_idx       = miss_pc_q[INDEX_WIDTH-1:0];
  assign fill_tag       = miss_pc_q[ADDR_WIDTH-3:INDEX_WIDTH];
  assign hit            = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_pc_bits = ^bus.if_pc[1:0];

  always_comb begin
    state_d    = state_q;
    cancel_d   = cancel_q;
    miss_pc_d  = miss_pc_q;
    inst_ok_d  = 1'b0;
    inst_o_d   = inst_o_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill       = 1'b0;
    acc_hit    = 1'b0;
    acc_miss   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.if_req && !flush) begin
          if (hit) begin
            acc_hit   = 1'b1;
            inst_ok_d = 1'b1;
            inst_o_d  = data_q[req_idx];
          end else begin
            acc_miss   = 1'b1;
            miss_pc_d  = bus.if_pc[ADDR_WIDTH-1:2];
            mem_req_d  = 1'b1;
            mem_addr_d = {bus.if_pc[31:2], 2'b00};
            state_d    = StMiss;
          end
        end
      end
      StMiss: begin
        if (bus.mem_ack) begin
          fill      = 1'b1;
          mem_req_d = 1'b0;
          inst_o_d  = bus.mem_data;
          // A flush on the ack edge itself also kills the pulse.
          inst_ok_d = !(cancel_q || flush);
          cancel_d  = 1'b0;
          state_d   = StIdle;
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      miss_pc_q  <= '0;
      cancel_q   <= 1'b0;
      inst_ok_q  <= 1'b0;
      inst_o_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      miss_pc_q  <= miss_pc_d;
      cancel_q   <= cancel_d;
      inst_ok_q  <= inst_ok_d;
      inst_o_q   <= inst_o_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      // Invalidate beats a same-edge fill: the filled line stays invalid.
      if (inv) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data need no reset; valid_q gates every read.
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_data;
    end
  end

  assign bus.inst_ok  = inst_ok_q;
  assign bus.inst_o   = inst_o_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      if (acc_hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (acc_miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = acc_hit ^ acc_miss;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: vector table, hand-written corner sequences,
// and randomized fetches checked against a line-map reference model.
module tb_icache;
  localparam int unsigned Lines   = 64;
  localparam int unsigned AddrMod = 32'h0004_0000;

  logic clk = 1'b0;
  logic rst, rdy, flush, inv;
  always #5 clk = ~clk;

  icache_if bus ();

  int n_tests = 0;
  int n_fail = 0;
  int exp_hits = 0;
  int exp_misses = 0;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .inv(inv), .bus(bus),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
`else
  icache dut (.clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .inv(inv), .bus(bus));
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          dly;
    bit          miss;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs [12];

  logic [31:0] m_data [int];
  int          m_tag  [int];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One IF request; on a miss mem_ctrl acks dly cycles after mem_req rises.
  task automatic fetch(input string name, input logic [31:0] pc, input logic [31:0] word,
                       input int dly, input bit exp_miss, input logic [31:0] exp_inst);
    logic        seen_req;
    logic [31:0] addr;
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    cyc();
    seen_req = bus.mem_req;
    addr     = bus.mem_addr;
    if (seen_req) begin
      for (int i = 1; i < dly; i++) cyc();
      chk({name, " req_hold"}, {31'b0, bus.mem_req}, 32'd1);
      bus.mem_ack  = 1'b1;
      bus.mem_data = word;
      cyc();
      bus.mem_ack  = 1'b0;
      bus.mem_data = $urandom;
      chk({name, " req_drop"}, {31'b0, bus.mem_req}, 32'd0);
    end
    bus.if_req = 1'b0;
    chk({name, " miss"}, {31'b0, seen_req}, {31'b0, exp_miss});
    if (exp_miss && seen_req) chk({name, " addr"}, addr, {pc[31:2], 2'b00});
    chk({name, " ok"}, {31'b0, bus.inst_ok}, 32'd1);
    chk({name, " inst"}, bus.inst_o, exp_inst);
    cyc();
    chk({name, " pulse"}, {31'b0, bus.inst_ok}, 32'd0);
    if (exp_miss) exp_misses++;
    else exp_hits++;
  endtask

  initial begin
    logic [31:0] pc, word, exp_inst;
    int          idx, tag;
    bit          exp_miss;

    rst = 1'b0; rdy = 1'b1; flush = 1'b0; inv = 1'b0;
    bus.if_req = 1'b0; bus.if_pc = '0; bus.mem_ack = 1'b0; bus.mem_data = '0;
    #1 rst = 1'b1;
    cyc();
    cyc();
    chk("rst inst_ok", {31'b0, bus.inst_ok}, 32'd0);
    chk("rst inst_o", bus.inst_o, 32'd0);
    chk("rst mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    rst = 1'b0;
    cyc();

    // Line 0 aliases 0x100/0x200/0x101; bits above bit 17 are outside the tag.
    vecs[0]  = '{32'h0000_0100, 32'h0000_0013, 2, 1'b1, 32'h0000_0013};
    vecs[1]  = '{32'h0000_0100, 32'h0,         1, 1'b0, 32'h0000_0013};
    vecs[2]  = '{32'h0000_0104, 32'h0000_0022, 1, 1'b1, 32'h0000_0022};
    vecs[3]  = '{32'h0000_0200, 32'h0000_0033, 3, 1'b1, 32'h0000_0033};
    vecs[4]  = '{32'h0000_0100, 32'h0000_0044, 1, 1'b1, 32'h0000_0044};
    vecs[5]  = '{32'h0000_0104, 32'h0,         1, 1'b0, 32'h0000_0022};
    vecs[6]  = '{32'h0000_0200, 32'h0000_0055, 2, 1'b1, 32'h0000_0055};
    vecs[7]  = '{32'h0003_FFFC, 32'h0000_0066, 1, 1'b1, 32'h0000_0066};
    vecs[8]  = '{32'h0003_FFFC, 32'h0,         1, 1'b0, 32'h0000_0066};
    vecs[9]  = '{32'hFFF3_FFFC, 32'h0,         1, 1'b0, 32'h0000_0066};
    vecs[10] = '{32'h0000_0101, 32'h0000_0077, 1, 1'b1, 32'h0000_0077};
    vecs[11] = '{32'h0000_0102, 32'h0,         1, 1'b0, 32'h0000_0077};
    for (int v = 0; v < 12; v++) begin
      fetch($sformatf("vec%0d", v), vecs[v].pc, vecs[v].word, vecs[v].dly,
            vecs[v].miss, vecs[v].inst);
    end

    // Back-to-back hits, one per cycle.
    bus.if_req = 1'b1; bus.if_pc = 32'h100;
    cyc(); chk("b2b ok0", {31'b0, bus.inst_ok}, 32'd1); chk("b2b inst0", bus.inst_o, 32'h77);
    bus.if_pc = 32'h104;
    cyc(); chk("b2b ok1", {31'b0, bus.inst_ok}, 32'd1); chk("b2b inst1", bus.inst_o, 32'h22);
    bus.if_pc = 32'h3FFFC;
    cyc(); chk("b2b ok2", {31'b0, bus.inst_ok}, 32'd1); chk("b2b inst2", bus.inst_o, 32'h66);
    bus.if_req = 1'b0;
    cyc(); chk("b2b end", {31'b0, bus.inst_ok}, 32'd0);
    exp_hits += 3;

    // Request dropped when flush arrives alongside it.
    bus.if_req = 1'b1; bus.if_pc = 32'h800; flush = 1'b1;
    cyc();
    bus.if_req = 1'b0; flush = 1'b0;
    chk("reqflush mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("reqflush ok", {31'b0, bus.inst_ok}, 32'd0);

    // Stray ack in IDLE is ignored.
    bus.mem_ack = 1'b1; bus.mem_data = 32'hDEAD_BEEF;
    cyc();
    bus.mem_ack = 1'b0;
    chk("idle ack ok", {31'b0, bus.inst_ok}, 32'd0);
    fetch("idle ack hit", 32'h100, 32'h0, 1, 1'b0, 32'h77);

    // Flush one cycle after mem_req: fill still lands, pulse suppressed.
    bus.if_req = 1'b1; bus.if_pc = 32'h500;
    cyc(); chk("fl mem_req", {31'b0, bus.mem_req}, 32'd1);
    flush = 1'b1; bus.if_req = 1'b0;
    cyc(); flush = 1'b0;
    chk("fl req kept", {31'b0, bus.mem_req}, 32'd1);
    bus.mem_ack = 1'b1; bus.mem_data = 32'h88;
    cyc(); bus.mem_ack = 1'b0;
    chk("fl no ok", {31'b0, bus.inst_ok}, 32'd0);
    chk("fl req drop", {31'b0, bus.mem_req}, 32'd0);
    cyc(); chk("fl still no ok", {31'b0, bus.inst_ok}, 32'd0);
    exp_misses++;
    fetch("fl refetch", 32'h500, 32'h0, 1, 1'b0, 32'h88);

    // Flush on the same edge as the ack.
    bus.if_req = 1'b1; bus.if_pc = 32'h600;
    cyc();
    bus.mem_ack = 1'b1; bus.mem_data = 32'h99; flush = 1'b1; bus.if_req = 1'b0;
    cyc(); bus.mem_ack = 1'b0; flush = 1'b0;
    chk("flack no ok", {31'b0, bus.inst_ok}, 32'd0);
    exp_misses++;
    fetch("flack refetch", 32'h600, 32'h0, 1, 1'b0, 32'h99);

    // inv on the ack edge: word forwarded, but the line stays invalid.
    bus.if_req = 1'b1; bus.if_pc = 32'h700;
    cyc();
    bus.mem_ack = 1'b1; bus.mem_data = 32'hAA; inv = 1'b1;
    cyc(); bus.mem_ack = 1'b0; inv = 1'b0; bus.if_req = 1'b0;
    chk("invack ok", {31'b0, bus.inst_ok}, 32'd1);
    chk("invack inst", bus.inst_o, 32'hAA);
    cyc();
    exp_misses++;
    fetch("invack repeat", 32'h700, 32'hAB, 1, 1'b1, 32'hAB);
    fetch("invack other", 32'h104, 32'hBB, 2, 1'b1, 32'hBB);

    // rdy low for 3 cycles while a hit pulse is out; inv and a miss request are frozen out.
    bus.if_req = 1'b1; bus.if_pc = 32'h104;
    cyc();
    chk("pause ok", {31'b0, bus.inst_ok}, 32'd1);
    exp_hits++;
    rdy = 1'b0; bus.if_pc = 32'h900; inv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("pause%0d ok", i), {31'b0, bus.inst_ok}, 32'd1);
      chk($sformatf("pause%0d inst", i), bus.inst_o, 32'hBB);
      chk($sformatf("pause%0d req", i), {31'b0, bus.mem_req}, 32'd0);
    end
    bus.if_req = 1'b0; inv = 1'b0; rdy = 1'b1;
    cyc(); chk("pause end", {31'b0, bus.inst_ok}, 32'd0);
    fetch("pause kept", 32'h104, 32'h0, 1, 1'b0, 32'hBB);

    // Randomized fetches against a line-map model.
    inv = 1'b1; cyc(); inv = 1'b0;
    m_data.delete(); m_tag.delete();
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        inv = 1'b1; cyc(); inv = 1'b0;
        m_data.delete(); m_tag.delete();
      end else begin
        pc = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 3)) << 8)
           | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        idx  = int'((pc >> 2) % Lines);
        tag  = int'((pc % AddrMod) / (Lines * 4));
        word = $urandom;
        exp_miss = !(m_tag.exists(idx) && m_tag[idx] == tag);
        exp_inst = exp_miss ? word : m_data[idx];
        fetch("rand", pc, word, int'($urandom_range(1, 4)), exp_miss, exp_inst);
        if (exp_miss) begin
          m_tag[idx]  = tag;
          m_data[idx] = word;
        end
      end
    end

    // Async reset in the middle of a miss.
    bus.if_req = 1'b1; bus.if_pc = 32'hA00;
    cyc();
    chk("arst pre req", {31'b0, bus.mem_req}, 32'd1);
    exp_misses++;
`ifdef ICACHE_STATS_EN
    chk("hit_cnt", hit_cnt, 32'(exp_hits));
    chk("miss_cnt", miss_cnt, 32'(exp_misses));
`endif
    #2 rst = 1'b1;
    #1;
    chk("arst mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("arst mem_addr", bus.mem_addr, 32'd0);
    chk("arst inst_o", bus.inst_o, 32'd0);
    chk("arst inst_ok", {31'b0, bus.inst_ok}, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("arst hit_cnt", hit_cnt, 32'd0);
    chk("arst miss_cnt", miss_cnt, 32'd0);
`endif
    bus.if_req = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    fetch("post rst", 32'h100, 32'h5, 1, 1'b1, 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
